multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the NPC core; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with valid-ready handshakes to the IFU and LSU.
- Decodes RV32I opcode classes into registered datapath controls.
- Covers all types: U, J, I, S, B, R, load/store, ebreak.
- Latches halt, illegal-instruction and timeout status.

Parameters:
ALUOP_W, 4, width of ALUOp output
TIMEOUT, 256, max wait cycles in FETCH or MEM before timeout halt; 0 disables timeout
RESET_STATE_IDLE, 1, 1: one IDLE cycle after reset before first FETCH; 0: reset straight into FETCH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ifu_req  out  1  instruction fetch request, held until accepted
ifu_rvalid  in  1  instruction data valid
ifu_rdata  in  32  fetched instruction
lsu_req  out  1  data memory request, held until done
lsu_wen  out  1  1 = store, 0 = load; valid while lsu_req
lsu_rvalid  in  1  data access complete
ImmType  out  3  U=0, J=1, I=2, S=3, B=4, none=7
PCSrc  out  1  0 = snpc, 1 = ALU/branch target
RegWEn  out  1  register write strobe, WB state only
ASrc  out  1  0 = rs1, 1 = pc
BSrc  out  1  0 = rs2, 1 = imm
ALUOp  out  ALUOP_W  ALU function code
WriteSrc  out  2  0 = ALU, 1 = snpc, 2 = memory
br_taken  in  1  branch comparator result from the datapath, sampled in EXEC
pc_wen  out  1  PC update strobe, WB state only
inst_out  out  32  latched current instruction
halt  out  1  sticky stop
illegal  out  1  sticky: halt caused by an unknown opcode
timeout  out  1  sticky: halt caused by a handshake timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async): state = IDLE (FETCH if RESET_STATE_IDLE = 0).
  - All outputs 0, except ImmType = 7.
  - inst_out = 0.
  - Wait counter = 0.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - ifu_req = 1.
  - On ifu_rvalid: latch ifu_rdata into inst_out, clear the counter, go to DECODE.
  - Same-cycle accept is allowed: a request and rvalid in the same cycle complete the fetch.
- DECODE (1 cycle): register all control outputs from inst_out[6:0].
  - Decode covers lui, auipc, jal, jalr, branch, load, store, op-imm, op, fence, system.
  - Exact 32'h00100073 (ebreak) -> HALT, halt = 1.
  - Unknown opcode -> HALT, halt = 1, illegal = 1. Control outputs are cleared to reset values.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - Branch: PCSrc = br_taken, sampled in this state.
  - Load/store -> MEM; all other classes -> WB.
- MEM:
  - lsu_req = 1; lsu_wen = 1 for store.
  - On lsu_rvalid: clear the counter, go to WB.
- WB (1 cycle):
  - pc_wen = 1.
  - RegWEn = 1 only for classes that write rd (not store, branch, fence), and only if rd != 0.
  - Next state FETCH.
- RegWEn and pc_wen are single-cycle pulses; they are never high outside WB.
- Timeout:
  - In FETCH and MEM the counter increments every cycle without a response.
  - When the counter reaches TIMEOUT (TIMEOUT > 0): HALT, halt = 1, timeout = 1, requests deasserted.
  - A response arriving in the same cycle as the counter hitting TIMEOUT counts as success.
- HALT: absorbing; every request and strobe is 0. Only rst leaves it.
- Reset mid-MEM or mid-FETCH: requests drop asynchronously. A later stale rvalid in IDLE is ignored.
- Latency with zero-wait memory: non-memory instruction = 4 cycles (FETCH, DECODE, EXEC, WB); load/store = 5 cycles.

Optional Feature:
- Macro: NPC_CTRL_PERF_EN.
- When defined, adds outputs perf_cycles (64) and perf_instret (64).
  - perf_cycles increments every cycle outside IDLE and HALT.
  - perf_instret increments on each WB.
  - Both reset to 0 and freeze in HALT.
- When undefined, those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- addi x1,x0,5 (32'h00500093), ifu_rvalid in the request cycle -> ImmType = 2, BSrc = 1, WriteSrc = 0; RegWEn and pc_wen pulse exactly once in the 4th cycle after FETCH entry.
- lw x2,0(x1) with lsu_rvalid 3 cycles after lsu_req rises -> lsu_req high for exactly 3 cycles, lsu_wen = 0, WriteSrc = 2, RegWEn pulse in the following cycle.
- beq with br_taken = 1 then with br_taken = 0 -> PCSrc 1 / 0, RegWEn never high, pc_wen pulses once each.
- Fetch 32'h00100073 -> halt = 1, illegal = 0, ifu_req stays 0 for 20 further cycles.
- Opcode 7'b1111111 -> halt = 1, illegal = 1. Separately, ifu_rvalid held low with TIMEOUT = 8 -> timeout = 1 after 8 FETCH cycles.
- Assert rst during MEM wait, then pulse lsu_rvalid after release -> lsu_req drops immediately, state restarts at IDLE, the stale rvalid has no effect; with NPC_CTRL_PERF_EN the counters read 0 after reset.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// IFU/LSU valid-ready handshake bundle used by multicycle_ctrl.
interface multicycle_ctrl_if;
    logic        ifu_req;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_rvalid;

    modport master (output ifu_req, input ifu_rvalid, input ifu_rdata,
                    output lsu_req, output lsu_wen, input lsu_rvalid);
    modport slave  (input ifu_req, output ifu_rvalid, output ifu_rdata,
                    input lsu_req, input lsu_wen, output lsu_rvalid);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with IFU/LSU handshakes.
// Optional perf counters are built when NPC_CTRL_PERF_EN is defined.
module multicycle_ctrl #(
    parameter int ALUOP_W          = 4,
    parameter int TIMEOUT          = 256,
    parameter bit RESET_STATE_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    bus,
    output logic [2:0]           ImmType,
    output logic                 PCSrc,
    output logic                 RegWEn,
    output logic                 ASrc,
    output logic                 BSrc,
    output logic [ALUOP_W-1:0]   ALUOp,
    output logic [1:0]           WriteSrc,
    input  logic                 br_taken,
    output logic                 pc_wen,
    output logic [31:0]          inst_out,
    output logic                 halt,
    output logic                 illegal,
    output logic                 timeout
`ifdef NPC_CTRL_PERF_EN
    ,
    output logic [63:0]          perf_cycles,
    output logic [63:0]          perf_instret
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    // ALU code is {funct7[5], funct3}; 4'hF passes operand B through (lui).
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_PASSB = 4'hF;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        inst_r;
    logic               ifu_req_r, lsu_req_r, lsu_wen_r;
    logic [2:0]         imm_r;
    logic               pcsrc_r, regwen_r, asrc_r, bsrc_r, pc_wen_r;
    logic [ALUOP_W-1:0] alu_r;
    logic [1:0]         ws_r;
    logic               halt_r, illegal_r, timeout_r;

    logic [2:0] dec_imm_s;
    logic       dec_asrc_s, dec_bsrc_s, dec_jump_s, dec_br_s, dec_mem_s, dec_store_s;
    logic       dec_wrd_s, dec_ok_s;
    logic [3:0] dec_alu_s;
    logic [1:0] dec_ws_s;
    logic       wait_hit_s;

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic f7b5);
        return {f7b5, f3};
    endfunction

    assign wait_hit_s = TO_EN && (cnt_r == CNT_LAST);

    // Opcode-class decode of the latched instruction.
    always_comb begin
        dec_imm_s   = 3'd7;
        dec_asrc_s  = 1'b0;
        dec_bsrc_s  = 1'b0;
        dec_alu_s   = ALU_ADD;
        dec_ws_s    = 2'd0;
        dec_jump_s  = 1'b0;
        dec_br_s    = 1'b0;
        dec_mem_s   = 1'b0;
        dec_store_s = 1'b0;
        dec_wrd_s   = 1'b0;
        dec_ok_s    = 1'b1;
        case (inst_r[6:0])
            7'b0110111: begin dec_imm_s = 3'd0; dec_bsrc_s = 1'b1; dec_alu_s = ALU_PASSB; dec_wrd_s = 1'b1; end
            7'b0010111: begin dec_imm_s = 3'd0; dec_asrc_s = 1'b1; dec_bsrc_s = 1'b1; dec_wrd_s = 1'b1; end
            7'b1101111: begin dec_imm_s = 3'd1; dec_asrc_s = 1'b1; dec_bsrc_s = 1'b1;
                              dec_ws_s = 2'd1; dec_jump_s = 1'b1; dec_wrd_s = 1'b1; end
            7'b1100111: begin dec_imm_s = 3'd2; dec_bsrc_s = 1'b1;
                              dec_ws_s = 2'd1; dec_jump_s = 1'b1; dec_wrd_s = 1'b1; end
            7'b1100011: begin dec_imm_s = 3'd4; dec_asrc_s = 1'b1; dec_bsrc_s = 1'b1; dec_br_s = 1'b1; end
            7'b0000011: begin dec_imm_s = 3'd2; dec_bsrc_s = 1'b1; dec_ws_s = 2'd2;
                              dec_mem_s = 1'b1; dec_wrd_s = 1'b1; end
            7'b0100011: begin dec_imm_s = 3'd3; dec_bsrc_s = 1'b1; dec_mem_s = 1'b1; dec_store_s = 1'b1; end
            // funct7[5] is only an opcode modifier for srai among immediate ops
            7'b0010011: begin dec_imm_s = 3'd2; dec_bsrc_s = 1'b1; dec_wrd_s = 1'b1;
                              dec_alu_s = alu_code(inst_r[14:12], (inst_r[14:12] == 3'b101) & inst_r[30]); end
            7'b0110011: begin dec_alu_s = alu_code(inst_r[14:12], inst_r[30]); dec_wrd_s = 1'b1; end
            7'b0001111: begin dec_ok_s = 1'b1; end
            7'b1110011: begin dec_imm_s = 3'd2; dec_bsrc_s = 1'b1; dec_wrd_s = 1'b1; end
            default:    begin dec_ok_s = 1'b0; end
        endcase
    end

    // Main sequencer; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= RESET_STATE_IDLE ? S_IDLE : S_FETCH;
            ifu_req_r <= !RESET_STATE_IDLE;
            lsu_req_r <= 1'b0;
            lsu_wen_r <= 1'b0;
            cnt_r     <= '0;
            inst_r    <= 32'h0;
            imm_r     <= 3'd7;
            pcsrc_r   <= 1'b0;
            regwen_r  <= 1'b0;
            asrc_r    <= 1'b0;
            bsrc_r    <= 1'b0;
            alu_r     <= '0;
            ws_r      <= 2'd0;
            pc_wen_r  <= 1'b0;
            halt_r    <= 1'b0;
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            pc_wen_r <= 1'b0;
            regwen_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    state_r   <= S_FETCH;
                    ifu_req_r <= 1'b1;
                end
                S_FETCH: begin
                    if (bus.ifu_rvalid) begin
                        inst_r    <= bus.ifu_rdata;
                        cnt_r     <= '0;
                        ifu_req_r <= 1'b0;
                        state_r   <= S_DECODE;
                    end else if (wait_hit_s) begin
                        ifu_req_r <= 1'b0;
                        halt_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        state_r   <= S_HALT;
                    end else begin
                        cnt_r <= TO_EN ? cnt_r + 1'b1 : cnt_r;
                    end
                end
                S_DECODE: begin
                    if ((inst_r == EBREAK) || !dec_ok_s) begin
                        imm_r     <= 3'd7;
                        pcsrc_r   <= 1'b0;
                        asrc_r    <= 1'b0;
                        bsrc_r    <= 1'b0;
                        alu_r     <= '0;
                        ws_r      <= 2'd0;
                        halt_r    <= 1'b1;
                        illegal_r <= !dec_ok_s;
                        state_r   <= S_HALT;
                    end else begin
                        imm_r   <= dec_imm_s;
                        pcsrc_r <= dec_jump_s;
                        asrc_r  <= dec_asrc_s;
                        bsrc_r  <= dec_bsrc_s;
                        alu_r   <= ALUOP_W'(dec_alu_s);
                        ws_r    <= dec_ws_s;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pcsrc_r <= dec_br_s ? br_taken : pcsrc_r;
                    if (dec_mem_s) begin
                        lsu_req_r <= 1'b1;
                        lsu_wen_r <= dec_store_s;
                        state_r   <= S_MEM;
                    end else begin
                        pc_wen_r <= 1'b1;
                        regwen_r <= dec_wrd_s && (inst_r[11:7] != 5'd0);
                        state_r  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.lsu_rvalid) begin
                        lsu_req_r <= 1'b0;
                        lsu_wen_r <= 1'b0;
                        cnt_r     <= '0;
                        pc_wen_r  <= 1'b1;
                        regwen_r  <= dec_wrd_s && (inst_r[11:7] != 5'd0);
                        state_r   <= S_WB;
                    end else if (wait_hit_s) begin
                        lsu_req_r <= 1'b0;
                        lsu_wen_r <= 1'b0;
                        halt_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        state_r   <= S_HALT;
                    end else begin
                        cnt_r <= TO_EN ? cnt_r + 1'b1 : cnt_r;
                    end
                end
                S_WB: begin
                    ifu_req_r <= 1'b1;
                    state_r   <= S_FETCH;
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    ifu_req_r <= 1'b0;
                    lsu_req_r <= 1'b0;
                    halt_r    <= 1'b1;
                    state_r   <= S_HALT;
                end
            endcase
        end
    end

    assign bus.ifu_req = ifu_req_r;
    assign bus.lsu_req = lsu_req_r;
    assign bus.lsu_wen = lsu_wen_r;
    assign ImmType     = imm_r;
    assign PCSrc       = pcsrc_r;
    assign RegWEn      = regwen_r;
    assign ASrc        = asrc_r;
    assign BSrc        = bsrc_r;
    assign ALUOp       = alu_r;
    assign WriteSrc    = ws_r;
    assign pc_wen      = pc_wen_r;
    assign inst_out    = inst_r;
    assign halt        = halt_r;
    assign illegal     = illegal_r;
    assign timeout     = timeout_r;

`ifdef NPC_CTRL_PERF_EN
    logic [63:0] perf_cycles_r, perf_instret_r;

    // Active-cycle and retired-instruction counters, frozen in IDLE/HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_r  <= 64'd0;
            perf_instret_r <= 64'd0;
        end else begin
            perf_cycles_r  <= ((state_r != S_IDLE) && (state_r != S_HALT)) ? perf_cycles_r + 64'd1 : perf_cycles_r;
            perf_instret_r <= (state_r == S_WB) ? perf_instret_r + 64'd1 : perf_instret_r;
        end
    end

    assign perf_cycles  = perf_cycles_r;
    assign perf_instret = perf_instret_r;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: transaction-level model plus per-cycle compare.
module tb_multicycle_ctrl;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [2:0]  ImmType;
    logic        PCSrc, RegWEn, ASrc, BSrc, pc_wen, halt, illegal, timeout;
    logic [3:0]  ALUOp;
    logic [1:0]  WriteSrc;
    logic [31:0] inst_out;
`ifdef NPC_CTRL_PERF_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.ALUOP_W(4), .TIMEOUT(TO), .RESET_STATE_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .ImmType(ImmType), .PCSrc(PCSrc), .RegWEn(RegWEn), .ASrc(ASrc), .BSrc(BSrc),
        .ALUOp(ALUOp), .WriteSrc(WriteSrc), .br_taken(br_taken), .pc_wen(pc_wen),
        .inst_out(inst_out), .halt(halt), .illegal(illegal), .timeout(timeout)
`ifdef NPC_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int regwen_n = 0, pcwen_n = 0, lsureq_n = 0, ifureq_n = 0;
    int instret_exp = 0;

    logic        chk_en = 1'b0;
    logic        e_ifu, e_lsu, e_wen, e_pcw, e_rwe, e_halt, e_ill, e_to, e_ctrl;
    logic [2:0]  e_imm;
    logic        e_asrc, e_bsrc, e_pcsrc;
    logic [3:0]  e_alu;
    logic [1:0]  e_ws;
    logic [31:0] e_inst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: instruction class and the control values the spec assigns it.
    typedef enum {C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP, C_FENCE, C_SYS, C_BAD} cls_t;
    typedef struct packed {
        logic [2:0] imm; logic asrc, bsrc; logic [3:0] alu; logic [1:0] ws;
        logic jump, br, mem, store, wrd;
    } ref_t;

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'h37: return C_LUI;   7'h17: return C_AUIPC; 7'h6F: return C_JAL;
            7'h67: return C_JALR;  7'h63: return C_BR;    7'h03: return C_LD;
            7'h23: return C_ST;    7'h13: return C_OPI;   7'h33: return C_OP;
            7'h0F: return C_FENCE; 7'h73: return C_SYS;   default: return C_BAD;
        endcase
    endfunction

    function automatic ref_t model(input logic [31:0] i);
        ref_t r;
        cls_t c = classify(i[6:0]);
        r.imm   = (c == C_LUI || c == C_AUIPC) ? 3'd0 : (c == C_JAL) ? 3'd1 :
                  (c == C_ST) ? 3'd3 : (c == C_BR) ? 3'd4 :
                  (c == C_JALR || c == C_LD || c == C_OPI || c == C_SYS) ? 3'd2 : 3'd7;
        r.asrc  = (c == C_AUIPC || c == C_JAL || c == C_BR);
        r.bsrc  = !(c == C_OP || c == C_FENCE || c == C_BAD);
        r.ws    = (c == C_LD) ? 2'd2 : (c == C_JAL || c == C_JALR) ? 2'd1 : 2'd0;
        r.jump  = (c == C_JAL || c == C_JALR);
        r.br    = (c == C_BR);
        r.mem   = (c == C_LD || c == C_ST);
        r.store = (c == C_ST);
        r.wrd   = !(c == C_ST || c == C_BR || c == C_FENCE || c == C_BAD);
        if (c == C_LUI)      r.alu = 4'hF;
        else if (c == C_OP)  r.alu = {i[30], i[14:12]};
        else if (c == C_OPI) r.alu = {i[30] && (i[14:12] == 3'b101), i[14:12]};
        else                 r.alu = 4'h0;
        return r;
    endfunction

    // Compare process: DUT outputs against the expected values for the current cycle.
    always @(negedge clk) begin
        if (RegWEn) regwen_n++;
        if (pc_wen) pcwen_n++;
        if (bus.lsu_req) lsureq_n++;
        if (bus.ifu_req) ifureq_n++;
        if (chk_en) begin
            chk("ifu_req", 64'(bus.ifu_req), 64'(e_ifu));
            chk("lsu_req", 64'(bus.lsu_req), 64'(e_lsu));
            chk("pc_wen", 64'(pc_wen), 64'(e_pcw));
            chk("RegWEn", 64'(RegWEn), 64'(e_rwe));
            chk("halt", 64'(halt), 64'(e_halt));
            chk("illegal", 64'(illegal), 64'(e_ill));
            chk("timeout", 64'(timeout), 64'(e_to));
            if (e_lsu) chk("lsu_wen", 64'(bus.lsu_wen), 64'(e_wen));
            if (e_ctrl) begin
                chk("ImmType", 64'(ImmType), 64'(e_imm));
                chk("ASrc", 64'(ASrc), 64'(e_asrc));
                chk("BSrc", 64'(BSrc), 64'(e_bsrc));
                chk("ALUOp", 64'(ALUOp), 64'(e_alu));
                chk("WriteSrc", 64'(WriteSrc), 64'(e_ws));
                chk("PCSrc", 64'(PCSrc), 64'(e_pcsrc));
                chk("inst_out", 64'(inst_out), 64'(e_inst));
            end
        end
    end

    task automatic quiet_exp();
        e_ifu = 1'b0; e_lsu = 1'b0; e_wen = 1'b0; e_pcw = 1'b0; e_rwe = 1'b0; e_ctrl = 1'b0;
    endtask

    task automatic reset_exp();
        quiet_exp();
        e_halt = 1'b0; e_ill = 1'b0; e_to = 1'b0; e_ctrl = 1'b1;
        e_imm = 3'd7; e_asrc = 1'b0; e_bsrc = 1'b0; e_alu = 4'h0; e_ws = 2'd0; e_pcsrc = 1'b0;
        e_inst = 32'h0;
    endtask

    // Reset, one IDLE cycle, return at the start of the first FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        bus.ifu_rvalid = 1'b0; bus.ifu_rdata = 32'h0; bus.lsu_rvalid = 1'b0; br_taken = 1'b0;
        reset_exp();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        instret_exp = 0;
`ifdef NPC_CTRL_PERF_EN
        chk("perf_cycles_rst", perf_cycles, 64'd0);
        chk("perf_instret_rst", perf_instret, 64'd0);
`endif
        @(posedge clk); #1;
        e_ctrl = 1'b0;
    endtask

    // One instruction from FETCH entry through WB: fetch takes fwait cycles, MEM mwait cycles.
    task automatic run_instr(input logic [31:0] inst, input int fwait, input int mwait, input logic br);
        ref_t r;
        int   mem0, wb;
        r    = model(inst);
        mem0 = fwait + 2;
        wb   = r.mem ? mem0 + mwait : fwait + 2;
        for (int c = 0; c <= wb; c++) begin
            bus.ifu_rvalid = (c == fwait - 1);
            bus.ifu_rdata  = (c == fwait - 1) ? inst : 32'hDEAD_BEEF;
            bus.lsu_rvalid = r.mem && (c == wb - 1);
            br_taken       = br;
            e_ifu   = (c < fwait);
            e_lsu   = r.mem && (c >= mem0) && (c < wb);
            e_wen   = r.store;
            e_pcw   = (c == wb);
            e_rwe   = (c == wb) && r.wrd && (inst[11:7] != 5'd0);
            e_ctrl  = (c == wb);
            e_imm   = r.imm; e_asrc = r.asrc; e_bsrc = r.bsrc; e_alu = r.alu; e_ws = r.ws;
            e_pcsrc = r.jump || (r.br && br);
            e_inst  = inst;
`ifdef NPC_CTRL_PERF_EN
            if (c == wb) chk("perf_instret", perf_instret, 64'(instret_exp));
`endif
            if (c == wb) instret_exp++;
            @(posedge clk); #1;
        end
        bus.ifu_rvalid = 1'b0; bus.lsu_rvalid = 1'b0;
        quiet_exp();
    endtask

    // Fetch a halting instruction and watch HALT absorb 20 further cycles of stimulus.
    task automatic run_halt(input logic [31:0] inst, input logic ill);
        ref_t r;
        r = model(inst);
        for (int c = 0; c < 23; c++) begin
            bus.ifu_rvalid = (c == 0) || (c > 2);
            bus.ifu_rdata  = (c == 0) ? inst : 32'h0000_0093;
            bus.lsu_rvalid = (c > 2);
            e_ifu  = (c == 0);
            e_halt = (c >= 2);
            e_ill  = (c >= 2) && ill;
            e_ctrl = (c >= 2) && ill;
            e_imm = 3'd7; e_asrc = 1'b0; e_bsrc = 1'b0; e_alu = 4'h0; e_ws = 2'd0; e_pcsrc = 1'b0;
            e_inst = inst;
            if (c == 3) ifureq_n = 0;
            @(posedge clk); #1;
        end
        bus.ifu_rvalid = 1'b0; bus.lsu_rvalid = 1'b0;
        chk("halt_ifu_req_quiet", 64'(ifureq_n), 64'd0);
        chk("halt_class_unused", 64'(r.wrd), 64'(!ill));
    endtask

    initial begin
        int rw0, pw0, lr0;
        quiet_exp();
        do_reset();

        // addi x1,x0,5 with same-cycle fetch accept
        rw0 = regwen_n; pw0 = pcwen_n;
        run_instr(32'h0050_0093, 1, 0, 1'b0);
        chk("addi_ImmType", 64'(ImmType), 64'd2);
        chk("addi_BSrc", 64'(BSrc), 64'd1);
        chk("addi_WriteSrc", 64'(WriteSrc), 64'd0);
        chk("addi_regwen_pulses", 64'(regwen_n - rw0), 64'd1);
        chk("addi_pcwen_pulses", 64'(pcwen_n - pw0), 64'd1);

        // lw x2,0(x1) with three MEM cycles
        lr0 = lsureq_n; rw0 = regwen_n;
        run_instr(32'h0000_A103, 1, 3, 1'b0);
        chk("lw_lsu_req_cycles", 64'(lsureq_n - lr0), 64'd3);
        chk("lw_WriteSrc", 64'(WriteSrc), 64'd2);
        chk("lw_regwen_pulses", 64'(regwen_n - rw0), 64'd1);

        // beq taken, then not taken
        rw0 = regwen_n; pw0 = pcwen_n;
        run_instr(32'h0020_8463, 1, 0, 1'b1);
        chk("beq_taken_PCSrc", 64'(PCSrc), 64'd1);
        run_instr(32'h0020_8463, 1, 0, 1'b0);
        chk("beq_nt_PCSrc", 64'(PCSrc), 64'd0);
        chk("beq_regwen_pulses", 64'(regwen_n - rw0), 64'd0);
        chk("beq_pcwen_pulses", 64'(pcwen_n - pw0), 64'd2);

        // other classes: sw, lui, auipc, jal, add, sub, srai, nop to x0, fence
        run_instr(32'h0020_A223, 1, 2, 1'b0);
        run_instr(32'h1234_52B7, 1, 0, 1'b0);
        chk("lui_ALUOp", 64'(ALUOp), 64'hF);
        run_instr(32'h0000_1317, 1, 0, 1'b0);
        run_instr(32'h0100_00EF, 1, 0, 1'b0);
        chk("jal_PCSrc", 64'(PCSrc), 64'd1);
        run_instr(32'h0020_81B3, 1, 0, 1'b1);
        run_instr(32'h4020_81B3, 1, 0, 1'b0);
        chk("sub_ALUOp", 64'(ALUOp), 64'h8);
        run_instr(32'h4030_D213, 1, 0, 1'b0);
        chk("srai_ALUOp", 64'(ALUOp), 64'hD);
        rw0 = regwen_n;
        run_instr(32'h0000_0013, 1, 0, 1'b0);
        run_instr(32'h0000_000F, 1, 0, 1'b0);
        chk("x0_fence_regwen", 64'(regwen_n - rw0), 64'd0);

        // response on the very cycle the wait counter reaches TIMEOUT still succeeds
        run_instr(32'h0050_0093, TO, 0, 1'b0);
        run_instr(32'h0000_A103, 1, TO, 1'b0);
        chk("boundary_no_timeout", 64'(timeout), 64'd0);

        // reset during MEM wait, then stale lsu_rvalid in IDLE
        bus.ifu_rvalid = 1'b1; bus.ifu_rdata = 32'h0000_A103; e_ifu = 1'b1;
        @(posedge clk); #1;
        bus.ifu_rvalid = 1'b0; quiet_exp();
        repeat (2) begin @(posedge clk); #1; end
        e_lsu = 1'b1; e_wen = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        reset_exp();
        #1 chk("rst_lsu_req_async", 64'(bus.lsu_req), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.lsu_rvalid = 1'b1;
        instret_exp = 0;
`ifdef NPC_CTRL_PERF_EN
        chk("perf_cycles_midmem", perf_cycles, 64'd0);
        chk("perf_instret_midmem", perf_instret, 64'd0);
`endif
        @(posedge clk); #1;
        bus.lsu_rvalid = 1'b0;
        e_ctrl = 1'b0;
        run_instr(32'h0050_0093, 1, 0, 1'b0);

        // ebreak halts without illegal
        run_halt(32'h0010_0073, 1'b0);
        chk("ebreak_illegal", 64'(illegal), 64'd0);

        // unknown opcode halts with illegal
        do_reset();
        run_halt(32'h0000_007F, 1'b1);
        chk("bad_opcode_illegal", 64'(illegal), 64'd1);

        // fetch never answered: timeout after TO FETCH cycles
        do_reset();
        for (int c = 0; c < TO + 4; c++) begin
            e_ifu  = (c < TO);
            e_halt = (c >= TO);
            e_to   = (c >= TO);
            @(posedge clk); #1;
        end
        chk("fetch_timeout", 64'(timeout), 64'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
